// File: rtl/bus_pkg.sv
// Shared types for the bus memory responder: FSM states, latched request record
// and the wait-state counter width.
package bus_pkg;

  localparam int CNT_W        = 4;
  localparam int REQ_ADDR_MAX = 32;
  localparam int REQ_DATA_MAX = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } bus_state_t;

  // Sized for the widest supported bus; the top truncates back to its own widths.
  typedef struct packed {
    logic                    we;
    logic [REQ_ADDR_MAX-1:0] addr;
    logic [REQ_DATA_MAX-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_ram_array.sv
// Synchronous single-port RAM with read-first behaviour and registered read data.
// Contents are not reset.
module bus_ram_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Bus target in front of on-chip RAM: accepts one request, waits WAIT_CYCLES, responds.
// Define BUS_MEM_ADDR_CHECK_EN to flag out-of-range addresses instead of aliasing them.
module bus_mem_responder
  import bus_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              r,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  bus_state_t        state_q, state_d;
  bus_req_t          req_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept, access, acc_we, acc_err, ram_we;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign accept = (state_q == IDLE) && req_valid;
  assign access = (accept && (WAIT_CYCLES == 0)) ||
                  ((state_q == WAIT) && (cnt_q == CNT_W'(1)));

  // In IDLE the zero-wait access uses the live request; otherwise the latched one.
  assign acc_we    = (state_q == IDLE) ? req_we : req_q.we;
  assign ram_addr  = (state_q == IDLE) ? IDX_W'(req_addr) : IDX_W'(req_q.addr);
  assign ram_wdata = (state_q == IDLE) ? req_wdata : DATA_W'(req_q.wdata);
  assign ram_we    = r && access && acc_we && !acc_err;

`ifdef BUS_MEM_ADDR_CHECK_EN
  localparam int AW1 = ADDR_W + 1;
  logic err_q, err_in;
  assign err_in = {1'b0, req_addr} >= AW1'(DEPTH);
  always_ff @(posedge clk) begin
    if (!r)          err_q <= 1'b0;
    else if (accept) err_q <= err_in;
  end
  assign acc_err = (state_q == IDLE) ? err_in : err_q;
  assign rsp_err = (state_q == RESP) && err_q;
`else
  assign acc_err = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // The RAM output register is re-read from the held address, so it stays stable in RESP.
  assign rsp_rdata = ((state_q == RESP) && !req_q.we && !rsp_err) ? ram_rdata : '0;

  bus_ram_array #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!r) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= CNT_W'(WAIT_CYCLES);
        req_q <= '{we: req_we, addr: REQ_ADDR_MAX'(req_addr), wdata: REQ_DATA_MAX'(req_wdata)};
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
      end
      WAIT: if (cnt_q == CNT_W'(1)) state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench: dut_a runs with two wait states, dut_b with none.
module tb_bus_mem_responder;

  logic clk = 1'b0;
  logic r   = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic        a_req_valid = 1'b0, a_req_we = 1'b0, a_rsp_ready = 1'b0;
  logic [15:0] a_req_addr = '0;
  logic [7:0]  a_req_wdata = '0;
  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [7:0]  a_rsp_rdata;

  logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_rsp_ready = 1'b0;
  logic [15:0] b_req_addr = '0;
  logic [7:0]  b_req_wdata = '0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [7:0]  b_rsp_rdata;

  bus_mem_responder #(.ADDR_W(16), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .r(r),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  bus_mem_responder #(.ADDR_W(16), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .r(r),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  // lat counts posedges from the acceptance edge (inclusive) to the first rsp_valid; -1 on timeout.
  task automatic a_xact(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                        output int lat, output logic [7:0] rd, output logic er);
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    lat = 1;
    while (a_rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (a_rsp_valid !== 1'b1) lat = -1;
    rd = a_rsp_rdata;
    er = a_rsp_err;
    @(negedge clk); a_rsp_ready = 1'b1;
    @(posedge clk); #1; a_rsp_ready = 1'b0;
  endtask

  task automatic b_xact(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                        output int lat, output logic [7:0] rd, output logic er);
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wd;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    lat = 1;
    while (b_rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (b_rsp_valid !== 1'b1) lat = -1;
    rd = b_rsp_rdata;
    er = b_rsp_err;
    @(negedge clk); b_rsp_ready = 1'b1;
    @(posedge clk); #1; b_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat; logic [7:0] rd; logic er;
    a_xact(1'b1, 16'h0020, 8'h12, lat, rd, er);
    b_xact(1'b1, 16'h0020, 8'h12, lat, rd, er);
    @(negedge clk);
    r = 1'b0;
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 16'h0020; a_req_wdata = 8'hEE;
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 16'h0020; b_req_wdata = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (a_req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", a_req_ready); else passed++;
      checks++; if (a_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", a_rsp_valid); else passed++;
      checks++; if (a_rsp_rdata !== 8'h00) $display("FAIL reset_rsp_rdata: got %h want 00", a_rsp_rdata); else passed++;
      checks++; if (a_rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b want 0", a_rsp_err); else passed++;
      checks++; if (b_rsp_valid !== 1'b0) $display("FAIL reset_b_rsp_valid: got %b want 0", b_rsp_valid); else passed++;
    end
    @(negedge clk);
    r = 1'b1; a_req_valid = 1'b0; b_req_valid = 1'b0;
    a_xact(1'b0, 16'h0020, 8'h00, lat, rd, er);
    checks++; if (rd !== 8'h12) $display("FAIL reset_no_write_a: got %h want 12", rd); else passed++;
    b_xact(1'b0, 16'h0020, 8'h00, lat, rd, er);
    checks++; if (rd !== 8'h12) $display("FAIL reset_no_write_b: got %h want 12", rd); else passed++;
  endtask

  task automatic test_write_read();
    int lat; logic [7:0] rd; logic er;
    a_xact(1'b1, 16'h0010, 8'hA5, lat, rd, er);
    checks++; if (lat != 3) $display("FAIL wr_latency: got %0d want 3", lat); else passed++;
    checks++; if (rd !== 8'h00) $display("FAIL wr_rdata: got %h want 00", rd); else passed++;
    checks++; if (er !== 1'b0) $display("FAIL wr_err: got %b want 0", er); else passed++;
    a_xact(1'b0, 16'h0010, 8'h00, lat, rd, er);
    checks++; if (lat != 3) $display("FAIL rd_latency: got %0d want 3", lat); else passed++;
    checks++; if (rd !== 8'hA5) $display("FAIL rd_rdata: got %h want a5", rd); else passed++;
  endtask

  task automatic test_backpressure();
    int lat; logic [7:0] rd; logic er;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 16'h0010; a_req_wdata = 8'h00;
    @(posedge clk); #1;
    // Request inputs change mid-transaction and must be ignored.
    a_req_we = 1'b1; a_req_wdata = 8'hFF;
    lat = 1;
    while (a_rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != 3) $display("FAIL bp_latency: got %0d want 3", lat); else passed++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (a_rsp_valid !== 1'b1) $display("FAIL bp_hold_valid: got %b want 1", a_rsp_valid); else passed++;
      checks++; if (a_rsp_rdata !== 8'hA5) $display("FAIL bp_hold_rdata: got %h want a5", a_rsp_rdata); else passed++;
      checks++; if (a_req_ready !== 1'b0) $display("FAIL bp_req_ready: got %b want 0", a_req_ready); else passed++;
    end
    @(negedge clk);
    a_rsp_ready = 1'b1; a_req_valid = 1'b0; a_req_we = 1'b0;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    checks++; if (a_rsp_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", a_rsp_valid); else passed++;
    checks++; if (a_req_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", a_req_ready); else passed++;
    a_xact(1'b0, 16'h0010, 8'h00, lat, rd, er);
    checks++; if (rd !== 8'hA5) $display("FAIL bp_ignored_write: got %h want a5", rd); else passed++;
  endtask

  task automatic test_zero_wait();
    int lat; logic [7:0] rd; logic er;
    b_xact(1'b1, 16'h0005, 8'h3C, lat, rd, er);
    checks++; if (lat != 1) $display("FAIL zw_wr_latency: got %0d want 1", lat); else passed++;
    b_xact(1'b0, 16'h0005, 8'h00, lat, rd, er);
    checks++; if (lat != 1) $display("FAIL zw_rd_latency: got %0d want 1", lat); else passed++;
    checks++; if (rd !== 8'h3C) $display("FAIL zw_rd_rdata: got %h want 3c", rd); else passed++;
  endtask

  task automatic test_addr_wrap();
    int lat; logic [7:0] rd; logic er;
    a_xact(1'b1, 16'h0000, 8'h42, lat, rd, er);
    a_xact(1'b1, 16'h0100, 8'h77, lat, rd, er);
    checks++; if (lat != 3) $display("FAIL wrap_latency: got %0d want 3", lat); else passed++;
`ifdef BUS_MEM_ADDR_CHECK_EN
    checks++; if (er !== 1'b1) $display("FAIL wrap_wr_err: got %b want 1", er); else passed++;
    a_xact(1'b0, 16'h0100, 8'h00, lat, rd, er);
    checks++; if (er !== 1'b1) $display("FAIL wrap_rd_err: got %b want 1", er); else passed++;
    checks++; if (rd !== 8'h00) $display("FAIL wrap_rd_rdata: got %h want 00", rd); else passed++;
    a_xact(1'b0, 16'h0000, 8'h00, lat, rd, er);
    checks++; if (rd !== 8'h42) $display("FAIL wrap_addr0: got %h want 42", rd); else passed++;
`else
    checks++; if (er !== 1'b0) $display("FAIL wrap_wr_err: got %b want 0", er); else passed++;
    a_xact(1'b0, 16'h0000, 8'h00, lat, rd, er);
    checks++; if (rd !== 8'h77) $display("FAIL wrap_addr0: got %h want 77", rd); else passed++;
`endif
    checks++; if (er !== 1'b0) $display("FAIL wrap_addr0_err: got %b want 0", er); else passed++;
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic [7:0] rd; logic er;
    a_xact(1'b1, 16'h0003, 8'h11, lat, rd, er);
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 16'h0003; a_req_wdata = 8'h5A;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    checks++; if (a_req_ready !== 1'b0) $display("FAIL mid_wait_ready: got %b want 0", a_req_ready); else passed++;
    @(posedge clk);
    // Reset lands on the edge where the write would otherwise commit.
    @(negedge clk); r = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_rsp_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", a_rsp_valid); else passed++;
    checks++; if (a_req_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", a_req_ready); else passed++;
    @(negedge clk); r = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (a_rsp_valid !== 1'b0) $display("FAIL mid_rst_no_rsp: got %b want 0", a_rsp_valid); else passed++;
    a_xact(1'b0, 16'h0003, 8'h00, lat, rd, er);
    checks++; if (rd !== 8'h11) $display("FAIL mid_rst_discard: got %h want 11", rd); else passed++;
  endtask

  initial begin
    r = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); r = 1'b1;
    test_reset();
    test_write_read();
    test_backpressure();
    test_zero_wait();
    test_addr_wrap();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
